// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversed reorder buffer.
//   LOG2N_MAX    : largest supported log2 frame length
//   bank_state_t : per-bank record (frame complete flag + frame length)
//   bitrev_f     : reverse the low nbits of an index
package bitrev_pkg;

  localparam int unsigned LOG2N_MAX = 14;
  localparam int unsigned LEN_W     = 5;

  typedef struct packed {
    logic             full;
    logic [LEN_W-1:0] len_log2;
  } bank_state_t;

  // Full-width reversal, then shift down so only the low nbits take part.
  function automatic logic [LOG2N_MAX-1:0] bitrev_f(input logic [LOG2N_MAX-1:0] idx,
                                                    input logic [LEN_W-1:0]     nbits);
    logic [LOG2N_MAX-1:0] r;
    for (int i = 0; i < int'(LOG2N_MAX); i++) begin
      r[i] = idx[int'(LOG2N_MAX) - 1 - i];
    end
    return r >> (LEN_W'(LOG2N_MAX) - nbits);
  endfunction

endpackage

// File: rtl/bitrev_skid.sv
// Two-entry valid/ready skid buffer; outputs come straight from the head register.
//   in_valid/in_data   : push side (caller guarantees space via level_c)
//   out_valid/out_data : head entry, held stable while out_ready is low
//   out_ready          : consumer accept
//   level_c            : current occupancy (0..2)
module bitrev_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   level_c
);

  logic         tail_v;
  logic [W-1:0] tail_d;
  logic         pop_c;

  assign pop_c   = out_valid && out_ready;
  assign level_c = {1'b0, out_valid} + {1'b0, tail_v};

  // Head/tail shift: a pop promotes the tail, a push fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      tail_v    <= 1'b0;
      tail_d    <= '0;
    end else if (pop_c) begin
      if (tail_v) begin
        out_data <= tail_d;
        tail_v   <= in_valid;
        if (in_valid) tail_d <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        tail_v <= 1'b1;
        tail_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/bitrev_reorder.sv
// Streaming bit-reversed-order reorder buffer with ping-pong banks.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_data      : natural-order (or bit-reversed) sample input
//   out_valid/out_ready/out_data   : permuted sample output
//   out_last                       : final sample of each output frame
//   out_idx                        : natural-order index (RAM address) of the output sample
//   len_log2                       : runtime log2 frame length, only with BITREV_VARLEN_EN
module bitrev_reorder
  import bitrev_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2N  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef BITREV_VARLEN_EN
  input  logic [4:0]        len_log2,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [LOG2N-1:0]  out_idx
);

  localparam int unsigned N     = 1 << LOG2N;
  localparam int unsigned PAY_W = DATA_W + 1 + LOG2N;

  typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} rd_state_t;

  // Final counter value for a frame of 2**l samples.
  function automatic logic [LOG2N-1:0] last_cnt(input logic [LEN_W-1:0] l);
    return LOG2N'((32'd1 << l) - 32'd1);
  endfunction

  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  logic [LOG2N-1:0]  wr_cnt_q, rd_cnt_q;
  logic              wr_bank_q, rd_bank_q;
  rd_state_t         state_q, state_d;
  logic              rd_v_q, rd_last_q;
  logic [LOG2N-1:0]  rd_idx_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [2*N];

  logic [LEN_W-1:0]  wr_len_c, rd_len_c;
  logic              wr_acc_c, wr_done_c, wr_bank_nx_c;
  logic              issue_c, rd_last_c, space_c, pop_c;
  logic [LOG2N-1:0]  rd_addr_c;
  logic [1:0]        skid_level_c;
  logic [PAY_W-1:0]  skid_out;

  // Frame length for the frame being written: latched at its first sample.
`ifdef BITREV_VARLEN_EN
  logic [LEN_W-1:0] wr_len_q, len_clamp_c;
  assign len_clamp_c = (len_log2 < LEN_W'(2) || len_log2 > LEN_W'(LOG2N)) ? LEN_W'(LOG2N) : len_log2;
  assign wr_len_c    = (wr_cnt_q == '0) ? len_clamp_c : wr_len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wr_len_q <= LEN_W'(LOG2N);
    else if (wr_acc_c && wr_cnt_q == '0) wr_len_q <= len_clamp_c;
  end
`else
  assign wr_len_c = LEN_W'(LOG2N);
`endif

  assign wr_acc_c     = in_valid && in_ready;
  assign wr_done_c    = wr_acc_c && (wr_cnt_q == last_cnt(wr_len_c));
  assign wr_bank_nx_c = wr_bank_q ^ wr_done_c;

  assign rd_len_c  = bank_q[rd_bank_q].len_log2;
  assign rd_last_c = (rd_cnt_q == last_cnt(rd_len_c));
  assign rd_addr_c = LOG2N'(bitrev_f(LOG2N_MAX'(rd_cnt_q), rd_len_c));

  // Occupancy after this cycle's pop, plus the read in flight, must leave room.
  assign pop_c   = out_valid && out_ready;
  assign space_c = ({1'b0, skid_level_c} + {2'b00, rd_v_q}) < ({2'b00, pop_c} + 3'd2);

  // Reader FSM: issue starts in the same cycle a bank becomes visible as full.
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_q[rd_bank_q].full) begin
          issue_c = space_c;
          state_d = READ;
        end
      end
      READ: begin
        issue_c = bank_q[rd_bank_q].full && space_c;
        if (issue_c && rd_last_c) state_d = bank_q[~rd_bank_q].full ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank flags: writer and reader always touch different banks.
  always_comb begin
    bank_d = bank_q;
    if (wr_done_c) begin
      bank_d[wr_bank_q].full     = 1'b1;
      bank_d[wr_bank_q].len_log2 = wr_len_c;
    end
    if (issue_c && rd_last_c) bank_d[rd_bank_q].full = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) bank_q[b] <= '0;
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      in_ready  <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_last_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      bank_q   <= bank_d;
      state_q  <= state_d;
      in_ready <= !bank_d[wr_bank_nx_c].full;
      if (wr_acc_c) begin
        wr_cnt_q  <= wr_done_c ? '0 : wr_cnt_q + LOG2N'(1);
        wr_bank_q <= wr_bank_nx_c;
      end
      if (issue_c) begin
        rd_cnt_q  <= rd_last_c ? '0 : rd_cnt_q + LOG2N'(1);
        rd_bank_q <= rd_bank_q ^ rd_last_c;
      end
      rd_v_q    <= issue_c;
      rd_last_q <= issue_c && rd_last_c;
      rd_idx_q  <= issue_c ? rd_addr_c : '0;
    end
  end

  // Sample RAM: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[{wr_bank_q, wr_cnt_q}] <= in_data;
    if (issue_c)  rd_data_q <= mem[{rd_bank_q, rd_addr_c}];
  end

  bitrev_skid #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_v_q),
    .in_data   ({rd_data_q, rd_last_q, rd_idx_q}),
    .out_valid (out_valid),
    .out_data  (skid_out),
    .out_ready (out_ready),
    .level_c   (skid_level_c)
  );

  assign {out_data, out_last, out_idx} = skid_out;

endmodule

// File: tb/tb_bitrev_reorder.sv
// Scoreboard bench for bitrev_reorder at LOG2N=3 (len_log2 frames with BITREV_VARLEN_EN).
module tb_bitrev_reorder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LOG2N  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              last;
    logic [LOG2N-1:0]  idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [LOG2N-1:0]  out_idx;
`ifdef BITREV_VARLEN_EN
  logic [4:0]        len_log2 = 5'd3;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   rise_cyc = 0;
  int   seen = 0;
  int   gaps = 0;
  bit   track = 1'b0;
  bit   rand_rdy = 1'b0;
  exp_t exp_q[$];

  // Hand-computed bit-reversal tables.
  int rev3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int rev2 [4] = '{0, 2, 1, 3};

  bitrev_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BITREV_VARLEN_EN
    .len_log2  (len_log2),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every handshake, checks hold-stability while stalled.
  exp_t              e;
  logic              hold_v = 1'b0;
  logic              prev_ov = 1'b0;
  logic [DATA_W-1:0] hold_d;
  logic              hold_l;
  logic [LOG2N-1:0]  hold_i;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v  = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(hold_d));
        chk("hold_last", 64'(out_last), 64'(hold_l));
        chk("hold_idx", 64'(out_idx), 64'(hold_i));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_data), 64'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_last", 64'(out_last), 64'(e.last));
          chk("out_idx", 64'(out_idx), 64'(e.idx));
        end
      end
      if (track) begin
        if (out_valid) seen++;
        else if (seen > 0 && seen < 32) gaps++;
      end
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      hold_v  = out_valid && !out_ready;
      hold_d  = out_data;
      hold_l  = out_last;
      hold_i  = out_idx;
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int g = 0; g < 400 && !ok; g++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_acc = cyc;
  endtask

  // Expected output of a frame whose input sample i carries data base+i.
  task automatic push_frame(input int base, input int nb);
    int a;
    exp_t x;
    for (int k = 0; k < (1 << nb); k++) begin
      a = (nb == 2) ? rev2[k] : rev3[k];
      x.d    = DATA_W'(base + a);
      x.last = (k == (1 << nb) - 1);
      x.idx  = LOG2N'(a);
      exp_q.push_back(x);
    end
  endtask

  task automatic send_frame(input int base, input int nb);
    push_frame(base, nb);
    for (int i = 0; i < (1 << nb); i++) send(DATA_W'(base + i));
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start, acc8, zeros, outs;

    // Reset values, and in_ready rising one edge after release.
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_pre_edge", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("in_ready_post_edge", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Single frame 0..7: order 0,4,2,6,1,5,3,7 and 2-clock latency.
    send_frame(0, 3);
    acc8 = last_acc;
    drain(200);
    chk("first_latency", 64'(rise_cyc - acc8), 64'(2));

    // Four back-to-back frames: no input stalls, no output bubbles.
    track = 1'b1;
    seen  = 0;
    gaps  = 0;
    start = cyc;
    for (int f = 0; f < 4; f++) send_frame(f * 8, 3);
    chk("input_no_stall", 64'(last_acc - start), 64'(32));
    drain(200);
    track = 1'b0;
    chk("output_count", 64'(seen), 64'(32));
    chk("output_bubbles", 64'(gaps), 64'(0));

    // Backpressure: both banks fill, in_ready drops, then recovers.
    out_ready = 1'b0;
    send_frame('h300, 3);
    send_frame('h308, 3);
    @(negedge clk);
    chk("in_ready_both_full", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    zeros = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (in_ready) break;
      zeros++;
    end
    chk("in_ready_recover_cycles", 64'(zeros), 64'(6));
    drain(200);

    // Random backpressure over ten frames.
    rand_rdy = 1'b1;
    for (int f = 0; f < 10; f++) send_frame('h400 + f * 8, 3);
    drain(3000);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset mid-frame: everything discarded, then a clean frame.
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send(DATA_W'('h200 + i));
    @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_last", 64'(out_last), 64'(0));
    chk("mid_rst_out_idx", 64'(out_idx), 64'(0));
    chk("mid_rst_out_data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    outs = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (out_valid) outs++;
    end
    chk("no_output_after_reset", 64'(outs), 64'(0));
    @(posedge clk);
    #1;
    send_frame(0, 3);
    drain(200);

`ifdef BITREV_VARLEN_EN
    // Runtime length: 4-point frame, then 8-point, then clamped out-of-range value.
    len_log2 = 5'd2;
    send_frame('h500, 2);
    drain(200);
    len_log2 = 5'd3;
    send_frame('h600, 3);
    drain(200);
    len_log2 = 5'd9;
    send_frame('h700, 3);
    drain(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
